mptw_request_arbiter: RTL and testbench

//  Shares one MPT walk pipeline (fetch stage slave port onward) between NUM_REQ requesters.
//  - Round-robin arbitration feeding a single registered master port.
//  - Each issued transaction is tagged with the requester ID.
//  - Bounds in-flight walks with a credit counter.
//  - Routes completion pulses from the pipeline tail back to the originating requester.

---
 rtl/mptw_request_arbiter.sv | 125 ++++++++++++
 tb/tb_mptw_request_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mptw_request_arbiter.sv
// Round-robin arbiter sharing one MPT walk pipeline among NUM_REQ requesters.
// Registered master port, requester-ID tagging, credit-bounded in-flight walks, completion routing.
module mptw_request_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          arb_enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rdata_i,
  output logic                          arb_master_valid_o,
  input  logic                          arb_master_ready_i,
  output logic [DATA_WIDTH-1:0]         arb_master_rdata_o,
  output logic [ID_WIDTH-1:0]           arb_master_id_o,
  input  logic                          rsp_valid_i,
  input  logic [ID_WIDTH-1:0]           rsp_id_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [CNT_WIDTH-1:0]          outstanding_o,
  output logic                          underflow_err_o
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  uf_q, uf_d;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  load_en;

  // First valid requester at or after the RR pointer, with wrap.
  always_comb begin : p_pick
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req_valid_i[ID_WIDTH'(idx)]) begin
        win_found = 1'b1;
        win_idx   = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin : p_next
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    uf_d        = uf_q;
    req_ready_o = '0;

    // Credit check uses the registered count only; a same-cycle completion cannot free a slot.
    load_en = rst_ni && arb_enable_i && win_found &&
              ((state_q == ST_EMPTY) || arb_master_ready_i) &&
              (cnt_q < CNT_WIDTH'(MAX_OUTSTANDING));

    case (state_q)
      ST_EMPTY: if (load_en) state_d = ST_FULL;
      ST_FULL:  if (!load_en && arb_master_ready_i) state_d = ST_EMPTY;
    endcase

    if (load_en) begin
      req_ready_o[win_idx] = 1'b1;
      data_d = req_rdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      id_d   = win_idx;
      ptr_d  = (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);
    end

    if (rsp_valid_i && (cnt_q == '0)) uf_d = 1'b1;
    if (load_en && !rsp_valid_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (!load_en && rsp_valid_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
    end
  end

  // Completion routing is stateless; out-of-range IDs match no requester.
  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rsp_valid_o[k] = rst_ni && rsp_valid_i && (rsp_id_i == ID_WIDTH'(k));
    end
  end

  assign arb_master_valid_o = (state_q == ST_FULL);
  assign arb_master_rdata_o = data_q;
  assign arb_master_id_o    = id_q;
  assign outstanding_o      = cnt_q;
  assign underflow_err_o    = uf_q;

endmodule

// File: tb/tb_mptw_request_arbiter.sv
// Self-checking bench for mptw_request_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_mptw_request_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MX = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          arb_enable_i;
  logic [N-1:0]  req_valid_i;
  logic [N-1:0]  req_ready_o;
  logic [N*DW-1:0] req_rdata_i;
  logic          arb_master_valid_o;
  logic          arb_master_ready_i;
  logic [DW-1:0] arb_master_rdata_o;
  logic [IW-1:0] arb_master_id_o;
  logic          rsp_valid_i;
  logic [IW-1:0] rsp_id_i;
  logic [N-1:0]  rsp_valid_o;
  logic [CW-1:0] outstanding_o;
  logic          underflow_err_o;

  mptw_request_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .arb_enable_i(arb_enable_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rdata_i(req_rdata_i),
    .arb_master_valid_o(arb_master_valid_o), .arb_master_ready_i(arb_master_ready_i),
    .arb_master_rdata_o(arb_master_rdata_o), .arb_master_id_o(arb_master_id_o),
    .rsp_valid_i(rsp_valid_i), .rsp_id_i(rsp_id_i), .rsp_valid_o(rsp_valid_o),
    .outstanding_o(outstanding_o), .underflow_err_o(underflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one holding slot, a credit count, the next-priority requester.
  bit          m_held;
  logic [DW-1:0] m_data;
  int          m_id;
  int          m_cnt;
  int          m_ptr;
  bit          m_uf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_data = '0; m_id = 0; m_cnt = 0; m_ptr = 0; m_uf = 0;
  endtask

  function automatic int model_winner();
    if (!arb_enable_i || m_cnt >= MX || (m_held && !arb_master_ready_i)) return -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (req_valid_i[k]) return k;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs applied; compares, then advances model across posedge.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
    #1;
    w = model_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_rsp = '0;
    if (rsp_valid_i) exp_rsp[rsp_id_i] = 1'b1;
    check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp));
    check("master_valid", 64'(arb_master_valid_o), 64'(m_held));
    if (m_held) begin
      check("master_data", 64'(arb_master_rdata_o), 64'(m_data));
      check("master_id", 64'(arb_master_id_o), 64'(m_id));
    end
    check("outstanding", 64'(outstanding_o), 64'(m_cnt));
    check("underflow", 64'(underflow_err_o), 64'(m_uf));
    @(posedge clk_i);
    if (rsp_valid_i && m_cnt == 0) m_uf = 1;
    if (w >= 0 && !rsp_valid_i) m_cnt++;
    else if (w < 0 && rsp_valid_i && m_cnt > 0) m_cnt--;
    if (w >= 0) begin
      m_held = 1;
      m_data = req_rdata_i[w*DW +: DW];
      m_id   = w;
      m_ptr  = (w + 1) % N;
    end else if (m_held && arb_master_ready_i) begin
      m_held = 0;
    end
    @(negedge clk_i);
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic rdy, input logic rv, input int rid);
    req_valid_i = v;
    arb_master_ready_i = rdy;
    rsp_valid_i = rv;
    rsp_id_i = IW'(rid);
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    arb_enable_i = 1'b1;
    set_in('0, 1'b0, 1'b0, 0);
    for (int k = 0; k < N; k++) req_rdata_i[k*DW +: DW] = 32'hC0DE_0000 + DW'(k);
    req_rdata_i[31:0] = 32'hA5A5_0001;
    model_reset();
    @(negedge clk_i);
    #1;
    check("rst_valid", 64'(arb_master_valid_o), 64'd0);
    check("rst_data", 64'(arb_master_rdata_o), 64'd0);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Single request from requester 0.
    set_in(4'b0001, 1'b1, 1'b0, 0);
    #1 check("t2_ready", 64'(req_ready_o), 64'h1);
    step();
    set_in('0, 1'b1, 1'b0, 0);
    #1;
    check("t2_valid", 64'(arb_master_valid_o), 64'd1);
    check("t2_id", 64'(arb_master_id_o), 64'd0);
    check("t2_data", 64'(arb_master_rdata_o), 64'hA5A5_0001);
    check("t2_outstanding", 64'(outstanding_o), 64'd1);
    step();

    // All requesters valid after reset: grants 0..3, then credit stall.
    pulse_reset();
    set_in(4'b1111, 1'b1, 1'b0, 0);
    for (int g = 0; g < 4; g++) begin
      #1 check("t3_grant", 64'(req_ready_o), 64'(1 << g));
      step();
    end
    #1;
    check("t3_stall", 64'(req_ready_o), 64'd0);
    check("t3_outstanding", 64'(outstanding_o), 64'd4);
    step();

    // Completion at full credit, then completion together with accept.
    set_in(4'b1111, 1'b1, 1'b1, 1);
    #1 check("t5_rsp", 64'(rsp_valid_o), 64'b0010);
    step();
    check("t5_outstanding", 64'(outstanding_o), 64'd3);
    set_in(4'b1111, 1'b1, 1'b1, 2);
    #1 check("t5_resume", 64'(req_ready_o), 64'b0001);
    step();
    check("t5_held", 64'(outstanding_o), 64'd3);

    // Backpressure hold, then swap-in on release.
    set_in(4'b1111, 1'b0, 1'b0, 0);
    for (int c = 0; c < 3; c++) begin
      #1 check("t4_blocked", 64'(req_ready_o), 64'd0);
      step();
    end
    check("t4_stable_id", 64'(arb_master_id_o), 64'd0);
    set_in(4'b0100, 1'b1, 1'b0, 0);
    #1 check("t4_swap", 64'(req_ready_o), 64'b0100);
    step();
    check("t4_new_id", 64'(arb_master_id_o), 64'd2);
    check("t4_new_data", 64'(arb_master_rdata_o), 64'hC0DE_0002);
    check("t4_outstanding", 64'(outstanding_o), 64'd4);

    // Drain credits, then underflow.
    for (int r = 0; r < 4; r++) begin
      set_in('0, 1'b1, 1'b1, r);
      step();
    end
    check("t6_zero", 64'(outstanding_o), 64'd0);
    set_in('0, 1'b1, 1'b1, 3);
    step();
    check("t6_underflow", 64'(underflow_err_o), 64'd1);
    set_in('0, 1'b1, 1'b0, 0);
    step();
    step();
    check("t6_sticky", 64'(underflow_err_o), 64'd1);
    check("t6_cnt_floor", 64'(outstanding_o), 64'd0);

    // Arbitration disabled.
    arb_enable_i = 1'b0;
    set_in(4'b1111, 1'b1, 1'b0, 0);
    for (int c = 0; c < 3; c++) begin
      #1 check("t6_disabled", 64'(req_ready_o), 64'd0);
      step();
    end
    arb_enable_i = 1'b1;

    // Asynchronous reset while a transaction is held.
    set_in(4'b0001, 1'b0, 1'b0, 0);
    step();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("t1_valid", 64'(arb_master_valid_o), 64'd0);
    check("t1_outstanding", 64'(outstanding_o), 64'd0);
    check("t1_ready", 64'(req_ready_o), 64'd0);
    check("t1_underflow", 64'(underflow_err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) req_rdata_i[k*DW +: DW] = DW'($urandom);
      arb_enable_i = ($urandom_range(0, 9) != 0);
      set_in(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
             int'($urandom_range(0, N - 1)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
